// File: rtl/memory_loader_pkg.sv
// Shared types and constants for the boot-time memory loader.
// Holds the FSM state encoding, frame field names and default frame parameters.
package loader_pkg;

  localparam int unsigned WORD_WIDTH  = 16;
  localparam int unsigned INDEX_WIDTH = 14;
  localparam logic [7:0]  DEFAULT_MAGIC = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } state_t;

  // Byte positions within a frame: MAGIC, length (high then low), payload, checksum.
  typedef enum logic [2:0] {
    FIELD_MAGIC,
    FIELD_LEN_HI,
    FIELD_LEN_LO,
    FIELD_PAYLOAD,
    FIELD_CSUM
  } frame_field_t;

endpackage

// File: rtl/memory_loader_if.sv
// Byte-stream input and RAM/CPU-control output bundle of the memory loader.
// master = byte source / system side, slave = the loader itself.
interface memory_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [15:0] memory_address;
  logic        memory_write_enable;
  logic [15:0] memory_data_out;
  logic        cpu_reset_n;
  logic        load_done;
  logic        load_error;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, memory_address, memory_write_enable, memory_data_out,
           cpu_reset_n, load_done, load_error
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, memory_address, memory_write_enable, memory_data_out,
           cpu_reset_n, load_done, load_error
  );
endinterface

// File: rtl/memory_loader.sv
// Boot loader: parses MAGIC/LEN/data/CSUM frames from the UART, writes 16-bit
// words to consecutive RAM addresses and releases the CPU once the checksum matches.
module memory_loader
  import loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 8192,
  parameter logic [7:0]  MAGIC     = DEFAULT_MAGIC
) (
  input  logic            clock,
  input  logic            reset_n,
  memory_loader_if.slave  bus
);

  state_t                 state, next_state;
  logic [7:0]             len_hi;
  logic [15:0]            len;
  logic [INDEX_WIDTH-1:0] index;
  logic [7:0]             csum;
  logic [7:0]             word_hi;
  logic                   xfer;
  logic [16:0]            len_rx;
  logic                   last_word;

  assign xfer      = bus.rx_valid & bus.rx_ready;
  assign len_rx    = {1'b0, len_hi, bus.rx_data};
  assign last_word = (16'(index) + 16'd1) == len;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state   = state;
    bus.rx_ready = (state != WRITE);
    unique case (state)
      IDLE, ERROR: if (xfer && bus.rx_data == MAGIC) next_state = LEN_HI;
      LEN_HI:      if (xfer) next_state = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if (len_rx > 17'(MAX_WORDS)) next_state = ERROR;
          else if (len_rx == '0)       next_state = CSUM;
          else                         next_state = DATA_HI;
        end
      end
      DATA_HI:     if (xfer) next_state = DATA_LO;
      DATA_LO:     if (xfer) next_state = WRITE;
      WRITE:       next_state = last_word ? CSUM : DATA_HI;
      CSUM:        if (xfer) next_state = (bus.rx_data == csum) ? DONE : ERROR;
      DONE:        next_state = DONE;
      default:     next_state = IDLE;
    endcase
  end

  // Status flags follow next_state so they appear one cycle after the deciding byte;
  // the write strobe is loaded on the DATA_LO transfer and is therefore high only in WRITE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.memory_address      <= BASE_ADDR;
      bus.memory_write_enable <= 1'b0;
      bus.memory_data_out     <= '0;
      bus.cpu_reset_n         <= 1'b0;
      bus.load_done           <= 1'b0;
      bus.load_error          <= 1'b0;
      len_hi                  <= '0;
      len                     <= '0;
      index                   <= '0;
      csum                    <= '0;
      word_hi                 <= '0;
    end else begin
      bus.memory_write_enable <= 1'b0;
      bus.load_done           <= (next_state == DONE);
      bus.cpu_reset_n         <= (next_state == DONE);
      bus.load_error          <= (next_state == ERROR);
      unique case (state)
        IDLE, ERROR: begin
          if (xfer && bus.rx_data == MAGIC) begin
            index <= '0;
            csum  <= '0;
          end
        end
        LEN_HI: if (xfer) len_hi <= bus.rx_data;
        LEN_LO: if (xfer) len <= len_rx[15:0];
        DATA_HI: begin
          if (xfer) begin
            word_hi <= bus.rx_data;
            csum    <= csum ^ bus.rx_data;
          end
        end
        DATA_LO: begin
          if (xfer) begin
            csum                    <= csum ^ bus.rx_data;
            bus.memory_write_enable <= 1'b1;
            bus.memory_address      <= BASE_ADDR + 16'(index);
            bus.memory_data_out     <= {word_hi, bus.rx_data};
          end
        end
        WRITE:   index <= index + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_loader.sv
// Scoreboarded bench for memory_loader: a stream-level frame parser predicts RAM
// writes and final status; a negedge monitor checks every write strobe against it.
module tb_memory_loader;
  import loader_pkg::*;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int unsigned MAXW = 8192;
  localparam logic [7:0]  MG   = 8'hA5;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;
  wr_t exp_q[$];
  logic [7:0] stream[$];

  always #5 clock = ~clock;

  memory_loader_if bus();

  memory_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW),
    .MAGIC(MG)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every write strobe.
  always @(negedge clock) begin
    if (reset_n) begin
      check("rx_ready_vs_strobe", 32'(bus.rx_ready), 32'(!bus.memory_write_enable));
      if (bus.memory_write_enable) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                   bus.memory_address, bus.memory_data_out);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_addr", 32'(bus.memory_address), 32'(e.addr));
          check("write_data", 32'(bus.memory_data_out), 32'(e.data));
        end
      end
    end
  end

  // Reference: walk the byte stream frame by frame from an idle start.
  function automatic void model(input logic [7:0] s[$], output bit done, output bit err);
    int unsigned p;
    int unsigned n;
    logic [7:0]  cs;
    done = 1'b0;
    err  = 1'b0;
    p    = 0;
    while (p < s.size() && !done) begin
      if (s[p] != MG) begin
        p++;
        continue;
      end
      p++;
      err = 1'b0;
      n = {s[p], s[p+1]};
      p += 2;
      if (n > MAXW) begin
        err = 1'b1;
        continue;
      end
      cs = '0;
      for (int unsigned i = 0; i < n; i++) begin
        exp_q.push_back('{BASE + 16'(i), {s[p], s[p+1]}});
        cs ^= s[p] ^ s[p+1];
        p += 2;
      end
      if (s[p] == cs) done = 1'b1;
      else            err  = 1'b1;
      p++;
    end
  endfunction

  function automatic void add_garbage(input int unsigned k);
    logic [7:0] b;
    for (int unsigned i = 0; i < k; i++) begin
      b = 8'($urandom);
      if (b == MG) b = 8'h00;
      stream.push_back(b);
    end
  endfunction

  function automatic void add_frame(input int unsigned n, input bit bad);
    logic [7:0] cs;
    logic [7:0] b;
    logic [15:0] len16;
    len16 = 16'(n);
    cs = '0;
    stream.push_back(MG);
    stream.push_back(len16[15:8]);
    stream.push_back(len16[7:0]);
    for (int unsigned i = 0; i < 2 * n; i++) begin
      b = 8'($urandom);
      cs ^= b;
      stream.push_back(b);
    end
    stream.push_back(bad ? ~cs : cs);
  endfunction

  // Called at a negedge; returns at the negedge following the transfer.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int unsigned w;
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus.rx_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    w = 0;
    while (!bus.rx_ready && w < 8) begin
      @(negedge clock);
      w++;
    end
    if (!bus.rx_ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got rx_ready 0 expected 1 within 8 cycles");
    end
    @(negedge clock);
  endtask

  task automatic run_segment(input string name, input bit gaps);
    bit d, e;
    model(stream, d, e);
    foreach (stream[i]) send_byte(stream[i], gaps);
    bus.rx_valid = 1'b0;
    check({name, "_load_done"}, 32'(bus.load_done), 32'(d));
    check({name, "_load_error"}, 32'(bus.load_error), 32'(e));
    check({name, "_cpu_reset_n"}, 32'(bus.cpu_reset_n), 32'(d));
    check({name, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    stream.delete();
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_address", 32'(bus.memory_address), 32'(BASE));
    check("rst_we", 32'(bus.memory_write_enable), 32'd0);
    check("rst_data", 32'(bus.memory_data_out), 32'd0);
    check("rst_cpu_reset_n", 32'(bus.cpu_reset_n), 32'd0);
    check("rst_load_done", 32'(bus.load_done), 32'd0);
    check("rst_load_error", 32'(bus.load_error), 32'd0);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] good[$];
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    @(negedge clock);
    do_reset();

    good = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    stream = good;
    run_segment("good2", 1'b1);

    do_reset();
    stream = good;
    stream[7] = 8'h41;
    run_segment("badcsum", 1'b1);
    stream = good;
    run_segment("resend", 1'b1);

    do_reset();
    stream = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
    run_segment("empty", 1'b1);

    do_reset();
    stream = '{8'hA5, 8'h20, 8'h01};
    run_segment("oversize", 1'b1);

    do_reset();
    add_frame(3, 1'b0);
    run_segment("held_valid", 1'b0);

    // Reset while the low byte of word 1 is being offered in DATA_LO.
    do_reset();
    exp_q.push_back('{BASE, 16'h1234});
    for (int i = 0; i < 6; i++) send_byte(good[i], 1'b0);
    bus.rx_data = good[6];
    bus.rx_valid = 1'b0;
    do_reset();
    stream = good;
    run_segment("after_reset", 1'b1);

    for (int it = 0; it < 10; it++) begin
      bit bad;
      do_reset();
      bad = ($urandom_range(0, 3) == 0);
      add_garbage($urandom_range(0, 3));
      add_frame($urandom_range(1, 8), bad);
      run_segment("rand", 1'b1);
      if (bad) begin
        add_garbage($urandom_range(0, 2));
        add_frame($urandom_range(1, 8), 1'b0);
        run_segment("rand_retry", 1'b1);
      end
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_loader.md
Name: memory_loader

Overview:
Boot-time writer for the unified program/data RAM's data port. It receives a framed byte stream from the UART receive path, assembles the bytes into 16-bit words, and writes them to consecutive RAM addresses. It verifies a trailing checksum. It holds the CPU in reset until a valid image has been loaded, then releases it.

Parameters:
BASE_ADDR, 16'h0000, first RAM word address written
MAX_WORDS, 8192, largest accepted image length in words (13-bit instruction space)
MAGIC, 8'hA5, frame start byte

Ports:
clock  in  1  system clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
rx_valid  in  1  received byte available
rx_data  in  8  received byte
rx_ready  out  1  loader accepts byte this cycle (transfer = rx_valid & rx_ready)
memory_address  out  16  RAM data-port address
memory_write_enable  out  1  one-cycle RAM write strobe
memory_data_out  out  16  word to RAM memory_data_in (`WIDTH = 16)
cpu_reset_n  out  1  low holds CPU in reset
load_done  out  1  image loaded and checksum good
load_error  out  1  frame rejected

Behaviour:
- Reset (asynchronous, reset_n low): state IDLE. All registered outputs are driven to these values: memory_address=BASE_ADDR, memory_write_enable=0, memory_data_out=0, cpu_reset_n=0, load_done=0, load_error=0. rx_ready=1.
- Frame format: MAGIC, LEN_HI, LEN_LO (N = 16-bit word count), then 2N data bytes with the high byte first in each word, then CSUM. CSUM is the XOR of all 2N data bytes.
- States and transitions:
  - IDLE: accept bytes. A MAGIC byte clears the word index, clears the checksum accumulator and clears load_error, then moves to LEN_HI. Any other byte is discarded and the state stays IDLE.
  - LEN_HI: latch len[15:8]; go to LEN_LO.
  - LEN_LO: latch len[7:0]. If N > MAX_WORDS, go to ERROR. If N == 0, go to CSUM. Otherwise go to DATA_HI.
  - DATA_HI: latch word[15:8] and XOR the byte into the checksum; go to DATA_LO.
  - DATA_LO: latch word[7:0] and XOR the byte into the checksum; go to WRITE.
  - WRITE: rx_ready=0. memory_write_enable=1 for exactly this cycle, with memory_address = BASE_ADDR + index and memory_data_out = the assembled word. Then increment index. If index+1 == N, go to CSUM; otherwise go to DATA_HI.
  - CSUM: accept one byte. If it equals the accumulator, go to DONE; otherwise go to ERROR.
  - DONE: load_done=1 and cpu_reset_n=1 (both registered, asserted one cycle after the CSUM transfer). rx_ready stays 1 and all bytes are discarded. DONE is sticky until reset_n.
  - ERROR: load_error=1 and cpu_reset_n=0. Non-MAGIC bytes are discarded. A MAGIC byte restarts the load exactly as from IDLE.
- Handshake and latency:
  - rx_ready=0 only in WRITE; rx_ready is a combinational decode of the state.
  - Write strobe latency: the write is issued in the cycle after the DATA_LO transfer.
  - Peak throughput is 1 word per 3 clocks; the UART rate is far lower.
- Address arithmetic: index is 14 bits. Address = BASE_ADDR + index, computed modulo 2^16 and wrapping silently.
- Partial writes: RAM words written before an ERROR remain in RAM; no rollback.
- rx_valid held high with constant data counts as one byte per accepted cycle; the source must advance its data after each transfer.
- Reset mid-frame: return immediately to reset values. Any partially written image is left in RAM, and cpu_reset_n stays 0.

Decomposition:
- Shared package loader_pkg:
  - state enum: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM, DONE, ERROR
  - MAGIC default
  - frame field names
- Single module; no sub-module is natural. Byte assembly and the checksum are a few registers each.

Test Plan:
- Frame A5 00 02 12 34 AB CD 40 → writes 16'h1234 @0 and 16'hABCD @1, each with a 1-cycle write strobe. load_done=1 and cpu_reset_n=1 one cycle after CSUM.
- Same frame with CSUM=41 → both words written, load_error=1, cpu_reset_n stays 0. Then resend the good frame → load_done=1, load_error=0.
- Frame A5 00 00 00 → no writes, load_done=1. Garbage bytes 00 FF before A5 → ignored, no writes.
- Frame A5 20 01 → N=8193 > MAX_WORDS → load_error=1, no writes.
- rx_valid held high continuously through a 3-word frame → rx_ready low for exactly 1 cycle after each DATA_LO, and no byte is lost or duplicated.
- reset_n pulsed low during DATA_LO of word 1 → outputs return to reset values immediately. A following full good frame then loads correctly from address 0.
